// File: rtl/oam_dma_master_if.sv
// oam_dma_master_if: CPU-side inputs and bus-master outputs of the $4014 sprite DMA block.
// The master modport is the DMA block's view; the slave modport is the CPU/bus-mux side.
interface oam_dma_master_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout;
   logic        cpu_rd;
   logic        odd_cycle;
   logic [7:0]  bus_din;
   logic        hijack;
   logic        cpu_halt;
   logic [15:0] m_addr;
   logic [7:0]  m_dout;
   logic        m_rd;
   logic        busy;

   modport master (
      input  cpu_addr, cpu_dout, cpu_rd, odd_cycle, bus_din,
      output hijack, cpu_halt, m_addr, m_dout, m_rd, busy
   );

   modport slave (
      output cpu_addr, cpu_dout, cpu_rd, odd_cycle, bus_din,
      input  hijack, cpu_halt, m_addr, m_dout, m_rd, busy
   );
endinterface

// File: rtl/oam_dma_master.sv
// oam_dma_master: a CPU write to DMA_REG takes the bus and copies one 256-byte page
// into sprite RAM via repeated writes to OAM_DATA_REG.
// Optional feature macro: OAM_DMA_ALIGN_EN inserts one ALIGN cycle when odd_cycle is
// high during HALT (514-cycle transfer); when undefined every transfer is 513 cycles.
module oam_dma_master #(
   parameter logic [15:0] DMA_REG      = 16'h4014,
   parameter logic [15:0] OAM_DATA_REG = 16'h2004
) (
   input logic              cpu_clk,
   input logic              reset,
   oam_dma_master_if.master bus
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StHalt  = 3'd1;
   localparam logic [2:0] StAlign = 3'd2;
   localparam logic [2:0] StRd    = 3'd3;
   localparam logic [2:0] StWr    = 3'd4;

   logic [2:0] state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;

`ifndef OAM_DMA_ALIGN_EN
   // Parity only matters when alignment is built in.
   logic unused_odd_cycle;
   assign unused_odd_cycle = bus.odd_cycle;
`endif

   // Next state: trigger only from idle, one halt cycle, optional align, then RD/WR pairs.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      data_d  = data_q;
      case (state_q)
         StIdle: begin
            if ((bus.cpu_addr == DMA_REG) && !bus.cpu_rd) begin
               state_d = StHalt;
               page_d  = bus.cpu_dout;
               idx_d   = 8'h00;
            end
         end
         StHalt: begin
`ifdef OAM_DMA_ALIGN_EN
            state_d = bus.odd_cycle ? StAlign : StRd;
`else
            state_d = StRd;
`endif
         end
         StAlign: state_d = StRd;
         StRd: begin
            data_d  = bus.bus_din;
            state_d = StWr;
         end
         StWr: begin
            // idx wraps to 0 on the last write so it reads 0 back in idle.
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == 8'hFF) ? StIdle : StRd;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset; reset aborts a transfer.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state_q <= StIdle;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   logic        own_bus;
   logic [15:0] m_addr;
   logic [7:0]  m_dout;
   logic        m_rd;

   // Outputs decoded from registered state only; no input reaches an output.
   always_comb begin
      own_bus = (state_q != StIdle);
      m_addr  = 16'h0000;
      m_dout  = 8'h00;
      m_rd    = 1'b1;
      case (state_q)
         StRd: m_addr = {page_q, idx_q};
         StWr: begin
            m_addr = OAM_DATA_REG;
            m_dout = data_q;
            m_rd   = 1'b0;
         end
         default: ;
      endcase
   end

   assign bus.hijack   = own_bus;
   assign bus.cpu_halt = own_bus;
   assign bus.busy     = own_bus;
   assign bus.m_addr   = m_addr;
   assign bus.m_dout   = m_dout;
   assign bus.m_rd     = m_rd;

endmodule

// File: tb/tb_oam_dma_master.sv
// tb_oam_dma_master: scoreboard bench for the $4014 sprite DMA block.
module tb_oam_dma_master;

   localparam logic [15:0] DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_REG  = 16'h2004;
`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic cpu_clk = 1'b0;
   logic reset   = 1'b1;
   always #5 cpu_clk = ~cpu_clk;

   oam_dma_master_if bus_if ();

   oam_dma_master #(
      .DMA_REG      (DMA_REG),
      .OAM_DATA_REG (OAM_REG)
   ) dut (
      .cpu_clk (cpu_clk),
      .reset   (reset),
      .bus     (bus_if)
   );

   // Source memory model: the addressed target answers within the cycle.
   logic [7:0] mem [0:65535];
   assign bus_if.bus_din = mem[bus_if.m_addr];

   int n_checks = 0;
   int n_fail   = 0;

   // Scoreboard: expected writes {addr,data} and expected read addresses.
   logic [23:0] exp_wr_q [$];
   logic [15:0] exp_rd_q [$];

   // Observed bus activity, written only by the monitor.
   logic [23:0] wr_q [$];
   logic [15:0] rd_q [$];
   int hij_cnt  = 0;
   int rd_first = 0;
   int last_wr  = 0;
   logic prev_hij = 1'b0;

   // Monitor: samples the master bus mid-cycle, numbering cycles from the first hijack cycle.
   always @(negedge cpu_clk) begin
      if (bus_if.hijack === 1'b1) begin
         hij_cnt <= prev_hij ? hij_cnt + 1 : 1;
         if (!prev_hij) rd_first <= 0;
         else if (bus_if.m_rd && bus_if.m_addr != 16'h0 && rd_first == 0) rd_first <= hij_cnt + 1;
         if (bus_if.m_rd && bus_if.m_addr != 16'h0) rd_q.push_back(bus_if.m_addr);
         if (!bus_if.m_rd) begin
            wr_q.push_back({bus_if.m_addr, bus_if.m_dout});
            last_wr <= hij_cnt + 1;
         end
      end
      prev_hij <= bus_if.hijack;
   end

   task automatic push_expected(input logic [7:0] page);
      for (int i = 0; i < 256; i++) begin
         exp_wr_q.push_back({OAM_REG, mem[{page, i[7:0]}]});
         exp_rd_q.push_back({page, i[7:0]});
      end
   endtask

   // Issue the trigger write; returns at mid-cycle of the HALT cycle.
   task automatic start_dma(input logic [7:0] page, input logic odd);
      @(negedge cpu_clk);
      bus_if.cpu_addr  = DMA_REG;
      bus_if.cpu_dout  = page;
      bus_if.cpu_rd    = 1'b0;
      bus_if.odd_cycle = odd;
      @(negedge cpu_clk);
      bus_if.cpu_addr = 16'h0000;
      bus_if.cpu_dout = 8'h00;
      bus_if.cpu_rd   = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while (bus_if.hijack === 1'b1 && i < budget) begin
         @(negedge cpu_clk);
         i++;
      end
      n_checks++;
      if (bus_if.hijack !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle: hijack=%b after %0d cycles, required 0", bus_if.hijack, i);
      end
      @(negedge cpu_clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge cpu_clk);
      reset = 1'b0;
      @(negedge cpu_clk);
      n_checks++;
      if ({bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_dout, bus_if.m_rd}
          !== {3'b000, 16'h0000, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_outputs: hij/halt/busy=%b%b%b addr=%h dout=%h rd=%b, required 000 0000 00 1",
                  bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_dout,
                  bus_if.m_rd);
      end
   endtask

   task automatic test_basic;
      int wb, rb;
      logic [23:0] gw;
      logic [15:0] gr, er;
      logic [23:0] ew;
      wb = wr_q.size();
      rb = rd_q.size();
      push_expected(8'h02);
      start_dma(8'h02, 1'b0);
      n_checks++;
      if ({bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_rd}
          !== {3'b111, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL basic_halt: hij/halt/busy=%b%b%b addr=%h rd=%b, required 111 0000 1",
                  bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_rd);
      end
      wait_idle(700);
      n_checks++;
      if (hij_cnt != 513) begin
         n_fail++;
         $display("FAIL basic_len: hijack cycles %0d, required 513", hij_cnt);
      end
      n_checks++;
      if (rd_first != 2 || last_wr != 513) begin
         n_fail++;
         $display("FAIL basic_timing: first RD %0d last WR %0d, required 2 and 513", rd_first, last_wr);
      end
      n_checks++;
      if (wr_q.size() - wb != 256) begin
         n_fail++;
         $display("FAIL basic_wr_count: %0d writes, required 256", wr_q.size() - wb);
      end
      for (int i = 0; i < 256; i++) begin
         ew = exp_wr_q.pop_front();
         er = exp_rd_q.pop_front();
         gw = (wb + i < wr_q.size()) ? wr_q[wb + i] : 24'hxxxxxx;
         gr = (rb + i < rd_q.size()) ? rd_q[rb + i] : 16'hxxxx;
         n_checks++;
         if (gw !== ew) begin
            n_fail++;
            $display("FAIL basic_wr[%0d]: got %h, required %h", i, gw, ew);
         end
         n_checks++;
         if (gr !== er) begin
            n_fail++;
            $display("FAIL basic_rd[%0d]: got %h, required %h", i, gr, er);
         end
      end
   endtask

   task automatic test_align;
      int wb, exp_len, exp_first;
      logic [23:0] gw, ew;
      exp_len   = ALIGN_EN ? 514 : 513;
      exp_first = ALIGN_EN ? 3 : 2;
      wb = wr_q.size();
      push_expected(8'h02);
      start_dma(8'h02, 1'b1);
      wait_idle(700);
      bus_if.odd_cycle = 1'b0;
      n_checks++;
      if (hij_cnt != exp_len) begin
         n_fail++;
         $display("FAIL align_len: hijack cycles %0d, required %0d", hij_cnt, exp_len);
      end
      n_checks++;
      if (rd_first != exp_first || last_wr != exp_len) begin
         n_fail++;
         $display("FAIL align_timing: first RD %0d last WR %0d, required %0d and %0d",
                  rd_first, last_wr, exp_first, exp_len);
      end
      exp_rd_q.delete();
      for (int i = 0; i < 256; i++) begin
         ew = exp_wr_q.pop_front();
         gw = (wb + i < wr_q.size()) ? wr_q[wb + i] : 24'hxxxxxx;
         n_checks++;
         if (gw !== ew) begin
            n_fail++;
            $display("FAIL align_wr[%0d]: got %h, required %h", i, gw, ew);
         end
      end
   endtask

   task automatic test_page_ff;
      int wb, rb;
      logic [15:0] gr, er;
      logic [23:0] gw, ew;
      wb = wr_q.size();
      rb = rd_q.size();
      push_expected(8'hFF);
      start_dma(8'hFF, 1'b0);
      wait_idle(700);
      n_checks++;
      if (rd_q.size() - rb != 256 || wr_q.size() - wb != 256) begin
         n_fail++;
         $display("FAIL ff_counts: %0d reads %0d writes, required 256 and 256",
                  rd_q.size() - rb, wr_q.size() - wb);
      end
      for (int i = 0; i < 256; i++) begin
         er = exp_rd_q.pop_front();
         ew = exp_wr_q.pop_front();
         gr = (rb + i < rd_q.size()) ? rd_q[rb + i] : 16'hxxxx;
         gw = (wb + i < wr_q.size()) ? wr_q[wb + i] : 24'hxxxxxx;
         n_checks++;
         if (gr !== er) begin
            n_fail++;
            $display("FAIL ff_rd[%0d]: got %h, required %h", i, gr, er);
         end
         n_checks++;
         if (gw !== ew) begin
            n_fail++;
            $display("FAIL ff_wr[%0d]: got %h, required %h", i, gw, ew);
         end
      end
      n_checks++;
      if (dut.idx_q !== 8'h00) begin
         n_fail++;
         $display("FAIL ff_idx_wrap: idx %h, required 00", dut.idx_q);
      end
   endtask

   task automatic test_no_trigger;
      @(negedge cpu_clk);
      bus_if.cpu_addr = DMA_REG;
      bus_if.cpu_dout = 8'h07;
      bus_if.cpu_rd   = 1'b1;
      @(negedge cpu_clk);
      bus_if.cpu_addr = 16'h4015;
      bus_if.cpu_rd   = 1'b0;
      @(negedge cpu_clk);
      bus_if.cpu_addr = 16'h0000;
      bus_if.cpu_rd   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (bus_if.hijack !== 1'b0 || bus_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger[%0d]: hijack=%b busy=%b, required 0 0", i, bus_if.hijack,
                     bus_if.busy);
         end
         @(negedge cpu_clk);
      end
   endtask

   task automatic test_back_to_back;
      int wb, rb;
      logic [15:0] gr, er;
      logic [23:0] gw, ew;
      wb = wr_q.size();
      rb = rd_q.size();
      push_expected(8'h02);
      @(negedge cpu_clk);
      bus_if.cpu_addr = DMA_REG;
      bus_if.cpu_dout = 8'h02;
      bus_if.cpu_rd   = 1'b0;
      @(negedge cpu_clk);
      bus_if.cpu_dout = 8'hFF;
      @(negedge cpu_clk);
      bus_if.cpu_addr = 16'h0000;
      bus_if.cpu_dout = 8'h00;
      bus_if.cpu_rd   = 1'b1;
      wait_idle(700);
      n_checks++;
      if (hij_cnt != 513 || wr_q.size() - wb != 256) begin
         n_fail++;
         $display("FAIL b2b_len: %0d cycles %0d writes, required 513 and 256", hij_cnt,
                  wr_q.size() - wb);
      end
      for (int i = 0; i < 256; i++) begin
         er = exp_rd_q.pop_front();
         ew = exp_wr_q.pop_front();
         gr = (rb + i < rd_q.size()) ? rd_q[rb + i] : 16'hxxxx;
         gw = (wb + i < wr_q.size()) ? wr_q[wb + i] : 24'hxxxxxx;
         n_checks++;
         if (gr !== er || gw !== ew) begin
            n_fail++;
            $display("FAIL b2b[%0d]: rd %h wr %h, required %h %h", i, gr, gw, er, ew);
         end
      end
      // Nothing further may start from the ignored second write.
      repeat (4) @(negedge cpu_clk);
      n_checks++;
      if (bus_if.hijack !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second: hijack=%b, required 0", bus_if.hijack);
      end
   endtask

   task automatic test_reset_mid;
      int wb, cnt, guard;
      logic [23:0] gw, ew;
      wb = wr_q.size();
      cnt = 0;
      guard = 0;
      start_dma(8'h03, 1'b0);
      while (cnt < 100 && guard < 600) begin
         @(negedge cpu_clk);
         guard++;
         if (bus_if.hijack === 1'b1 && bus_if.m_rd === 1'b0) cnt++;
      end
      reset = 1'b1;
      @(negedge cpu_clk);
      n_checks++;
      if ({bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_dout, bus_if.m_rd}
          !== {3'b000, 16'h0000, 8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_outputs: hij/halt/busy=%b%b%b addr=%h dout=%h rd=%b, required 000 0000 00 1",
                  bus_if.hijack, bus_if.cpu_halt, bus_if.busy, bus_if.m_addr, bus_if.m_dout,
                  bus_if.m_rd);
      end
      reset = 1'b0;
      repeat (20) @(negedge cpu_clk);
      n_checks++;
      if (cnt != 100 || wr_q.size() - wb > 100) begin
         n_fail++;
         $display("FAIL midreset_writes: saw %0d before reset, %0d total, required 100 and <=100",
                  cnt, wr_q.size() - wb);
      end
      wb = wr_q.size();
      push_expected(8'h05);
      exp_rd_q.delete();
      start_dma(8'h05, 1'b0);
      wait_idle(700);
      n_checks++;
      if (hij_cnt != 513 || wr_q.size() - wb != 256) begin
         n_fail++;
         $display("FAIL midreset_rerun: %0d cycles %0d writes, required 513 and 256", hij_cnt,
                  wr_q.size() - wb);
      end
      for (int i = 0; i < 256; i++) begin
         ew = exp_wr_q.pop_front();
         gw = (wb + i < wr_q.size()) ? wr_q[wb + i] : 24'hxxxxxx;
         n_checks++;
         if (gw !== ew) begin
            n_fail++;
            $display("FAIL midreset_wr[%0d]: got %h, required %h", i, gw, ew);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) begin
         logic [15:0] av;
         av = a[15:0];
         mem[a] = (av[7:0] * 8'd3) ^ av[15:8] ^ 8'h5A;
      end
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv;
         iv = i[7:0];
         mem[{8'h02, iv}] = iv ^ 8'hA5;
         mem[{8'hFF, iv}] = iv ^ 8'h3C;
         mem[{8'h03, iv}] = ~iv;
         mem[{8'h05, iv}] = iv * 8'd7 + 8'd3;
      end
      bus_if.cpu_addr  = 16'h0000;
      bus_if.cpu_dout  = 8'h00;
      bus_if.cpu_rd    = 1'b1;
      bus_if.odd_cycle = 1'b0;

      test_reset();
      test_basic();
      test_align();
      test_page_ff();
      test_no_trigger();
      test_back_to_back();
      test_reset_mid();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
